lsu_mem_if: RTL and testbench
=============================

// Module: lsu_mem_if
// PURPOSE
//  Load/store unit with bus handshake for the RV32I core: full sub-word support
//  (LB/LH/LW/LBU/LHU/SB/SH/SW), byte-enable generation, load sign/zero extension
//  and a req/gnt/rvalid memory handshake with a response timeout.
//  Sits between ALU (address), decode (operator, store data) and data memory;
//  stalls the core through lsu_busy_op while a transfer is in flight.
// PARAMETERS
//  ADDR_W          32   byte-address width; data_addr_op is word aligned
//  TIMEOUT_CYCLES  255  max cycles in REQ+WAIT_RSP before abort; 0 = no timeout
// PORTS
//  clock            in   1       rising-edge clock
//  reset            in   1       asynchronous, active-low reset
//  lsu_en_ip        in   1       decode: current instr is a memory op
//  lsu_operator_ip  in   enum    load_store_func_code (CORE_PKG)
//  alu_valid_ip     in   1       ALU address valid
//  mem_addr_ip      in   ADDR_W  effective byte address
//  store_data_ip    in   32      rs2 value for stores
//  data_req_op      out  1       memory request, held until granted
//  data_gnt_i       in   1       memory grant
//  data_addr_op     out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
//  data_we_op       out  1       1 = store
//  data_be_op       out  4       byte enables
//  data_wdata_op    out  32      lane-replicated store data
//  data_rvalid_i    in   1       memory response (load data or store ack)
//  data_rdata_i     in   32      raw load word
//  load_mem_data_op out  32      formatted load result, held until next load done
//  lsu_done_op      out  1       1-cycle pulse: transfer complete
//  lsu_busy_op      out  1       state != IDLE
//  misaligned_op    out  1       1-cycle pulse: address misaligned, no bus access
//  timeout_op       out  1       1-cycle pulse: transfer aborted
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, timeout counter 0, every output 0.
//  FSM IDLE -> REQ -> WAIT_RSP -> IDLE.
//  IDLE: accept when lsu_en_ip & alu_valid_ip. Alignment: word addr[1:0]==0,
//   half addr[0]==0, byte always. Misaligned: misaligned_op=1 next cycle, stay
//   IDLE, no req. Aligned: register addr/op/be/wdata, -> REQ.
//  REQ: data_req_op=1 with stable addr/we/be/wdata; gnt in a req cycle -> WAIT_RSP.
//  WAIT_RSP: req=0; on data_rvalid_i: loads register formatted data into
//   load_mem_data_op; lsu_done_op=1 next cycle; -> IDLE. Stores: rvalid = ack,
//   load_mem_data_op unchanged.
//  Latency: aligned op with gnt in first REQ cycle, rvalid 1 cycle later ->
//   done pulse 3 cycles after accept.
//  Requests while busy ignored (core must stall on lsu_busy_op).
//  rvalid in IDLE/REQ ignored; gnt outside REQ ignored.
//  Timeout: counter clears on accept, +1 per cycle in REQ/WAIT_RSP; reaching
//   TIMEOUT_CYCLES -> timeout_op pulse, req dropped, -> IDLE, no done.
//   rvalid and timeout same cycle: rvalid wins.
//  Store lanes: SB be=4'b0001<<a[1:0], wdata={4{d[7:0]}}; SH be=a[1]?1100:0011,
//   wdata={2{d[15:0]}}; SW be=1111, wdata=d.
//  Load format: LB/LBU byte lane a[1:0], sign/zero-extend; LH/LHU half lane a[1];
//   LW raw word.
// STRUCTURE
//  CORE_PKG: extend load_store_func_code with LB,LH,LBU,LHU,SB,SH; add
//   lsu_state_t {IDLE,REQ,WAIT_RSP}.
//  Sub-module lsu_lane_align (combinational): op+addr+data -> be/wdata/load-format.
// TESTING
//  SW 0x1000, d=0xDEADBEEF, gnt 1st cycle, rvalid next -> be=1111, we=1, done
//   3 cycles after accept.
//  LB 0x1003, rdata=0x80112233 -> 0xFFFFFF80; LBU -> 0x00000080; LHU 0x1002 -> 0x00008011.
//  SH 0x1002, d=0x0000ABCD -> be=1100, wdata=0xABCDABCD; SB 0x1001 d=0x5A -> be=0010.
//  LW 0x1002 -> misaligned_op pulse, data_req_op stays 0, busy stays 0.
//  gnt withheld 4 cycles -> req held, addr stable; TIMEOUT_CYCLES=8, no rvalid ->
//   timeout_op at cycle 8, IDLE, no done.
//  reset asserted in WAIT_RSP -> all outputs 0 immediately; later rvalid ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions for the load/store path: memory operator encoding,
// LSU state type and the alignment rule used before any bus access is issued.
package core_pkg;

    // Encoding is {is_store, is_unsigned, size[1:0]}; size 00=byte, 01=half, 10=word
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } load_store_func_code;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    function automatic logic addr_aligned(input logic [3:0] op, input logic [1:0] addr_lo);
        logic ok;
        case (op[1:0])
            SIZE_HALF: ok = ~addr_lo[0];
            SIZE_WORD: ok = (addr_lo == 2'b00);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for the
// outgoing request, and sign/zero-extended extraction of the returned load word.
module lsu_lane_align
    import core_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    always_comb begin
        be       = 4'b1111;
        wdata    = store_data;
        byte_sel = rdata[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sign_ext = ~op[2];
        load_data = rdata;
        case (op[1:0])
            SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            end
            SIZE_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit front end: accepts one memory op at a time, runs the
// req/gnt/rvalid handshake with an abort timeout, and formats load results.
module lsu_mem_if
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lsu_en_ip,
    input  logic [3:0]        lsu_operator_ip,
    input  logic              alu_valid_ip,
    input  logic [ADDR_W-1:0] mem_addr_ip,
    input  logic [31:0]       store_data_ip,
    output logic              data_req_op,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_op,
    output logic              data_we_op,
    output logic [3:0]        data_be_op,
    output logic [31:0]       data_wdata_op,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i,
    output logic [31:0]       load_mem_data_op,
    output logic              lsu_done_op,
    output logic              lsu_busy_op,
    output logic              misaligned_op,
    output logic              timeout_op
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_t       state, state_next;
    logic [3:0]       op_q;
    logic [1:0]       addr_lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept, aligned, timeout_hit;
    logic             done_set, timeout_set, misaligned_set;
    logic [3:0]       align_op;
    logic [1:0]       align_addr_lo;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata, lane_load;

    assign accept      = lsu_en_ip & alu_valid_ip;
    assign aligned     = addr_aligned(lsu_operator_ip, mem_addr_ip[1:0]);
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO_LIMIT);

    // The lane aligner sees the incoming op while idle and the captured op while the
    // transfer is in flight, so one instance serves both store steering and load formatting.
    assign align_op      = (state == IDLE) ? lsu_operator_ip : op_q;
    assign align_addr_lo = (state == IDLE) ? mem_addr_ip[1:0] : addr_lo_q;

    lsu_lane_align u_lane_align (
        .op         (align_op),
        .addr_lo    (align_addr_lo),
        .store_data (store_data_ip),
        .rdata      (data_rdata_i),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    assign data_req_op = (state == REQ);
    assign lsu_busy_op = (state != IDLE);

    always_comb begin
        state_next     = state;
        done_set       = 1'b0;
        timeout_set    = 1'b0;
        misaligned_set = 1'b0;
        case (state)
            IDLE: begin
                if (accept && aligned) begin
                    state_next = REQ;
                end else if (accept) begin
                    misaligned_set = 1'b1;
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    state_next  = IDLE;
                    timeout_set = 1'b1;
                end else if (data_gnt_i) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response arriving on the last allowed cycle still completes the transfer
                if (data_rvalid_i) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end else if (timeout_hit) begin
                    state_next  = IDLE;
                    timeout_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q             <= '0;
            addr_lo_q        <= '0;
            cnt_q            <= '0;
            data_addr_op     <= '0;
            data_we_op       <= 1'b0;
            data_be_op       <= '0;
            data_wdata_op    <= '0;
            load_mem_data_op <= '0;
            lsu_done_op      <= 1'b0;
            misaligned_op    <= 1'b0;
            timeout_op       <= 1'b0;
        end else begin
            lsu_done_op   <= done_set;
            misaligned_op <= misaligned_set;
            timeout_op    <= timeout_set;
            if (state == IDLE && accept && aligned) begin
                op_q          <= lsu_operator_ip;
                addr_lo_q     <= mem_addr_ip[1:0];
                cnt_q         <= '0;
                data_addr_op  <= {mem_addr_ip[ADDR_W-1:2], 2'b00};
                data_we_op    <= lsu_operator_ip[3];
                data_be_op    <= lane_be;
                data_wdata_op <= lane_wdata;
            end else if (state != IDLE) begin
                cnt_q <= cnt_inc;
            end
            if (done_set && !op_q[3]) begin
                load_mem_data_op <= lane_load;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: a vector table of single transfers plus
// hand-written sequences for grant stall, timeout, rvalid/timeout race and reset.
module tb_lsu_mem_if;
    import core_pkg::*;

    logic        clock;
    logic        reset;
    logic        lsu_en_ip;
    logic [3:0]  lsu_operator_ip;
    logic        alu_valid_ip;
    logic [31:0] mem_addr_ip;
    logic [31:0] store_data_ip;
    logic        data_req_op;
    logic        data_gnt_i;
    logic [31:0] data_addr_op;
    logic        data_we_op;
    logic [3:0]  data_be_op;
    logic [31:0] data_wdata_op;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic [31:0] load_mem_data_op;
    logic        lsu_done_op;
    logic        lsu_busy_op;
    logic        misaligned_op;
    logic        timeout_op;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        misal;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    lsu_mem_if #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .lsu_en_ip        (lsu_en_ip),
        .lsu_operator_ip  (lsu_operator_ip),
        .alu_valid_ip     (alu_valid_ip),
        .mem_addr_ip      (mem_addr_ip),
        .store_data_ip    (store_data_ip),
        .data_req_op      (data_req_op),
        .data_gnt_i       (data_gnt_i),
        .data_addr_op     (data_addr_op),
        .data_we_op       (data_we_op),
        .data_be_op       (data_be_op),
        .data_wdata_op    (data_wdata_op),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i),
        .load_mem_data_op (load_mem_data_op),
        .lsu_done_op      (lsu_done_op),
        .lsu_busy_op      (lsu_busy_op),
        .misaligned_op    (misaligned_op),
        .timeout_op       (timeout_op)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata);
        lsu_en_ip       = 1'b1;
        alu_valid_ip    = 1'b1;
        lsu_operator_ip = op;
        mem_addr_ip     = addr;
        store_data_ip   = sdata;
        next_cycle();
        lsu_en_ip    = 1'b0;
        alu_valid_ip = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " req"}, 32'(data_req_op), 32'h0);
        check_output({tag, " busy"}, 32'(lsu_busy_op), 32'h0);
        check_output({tag, " addr"}, data_addr_op, 32'h0);
        check_output({tag, " we"}, 32'(data_we_op), 32'h0);
        check_output({tag, " be"}, 32'(data_be_op), 32'h0);
        check_output({tag, " wdata"}, data_wdata_op, 32'h0);
        check_output({tag, " load"}, load_mem_data_op, 32'h0);
        check_output({tag, " done"}, 32'(lsu_done_op), 32'h0);
        check_output({tag, " misal"}, 32'(misaligned_op), 32'h0);
        check_output({tag, " tmo"}, 32'(timeout_op), 32'h0);
    endtask

    // One table entry: accept, grant in the first request cycle, response one cycle later
    task automatic apply_stimulus(input int i);
        vec_t  v;
        string t;
        v = vecs[i];
        t = $sformatf("v%0d", i);
        issue(v.op, v.addr, v.sdata);
        if (v.misal) begin
            check_output({t, " misal"}, 32'(misaligned_op), 32'h1);
            check_output({t, " req"}, 32'(data_req_op), 32'h0);
            check_output({t, " busy"}, 32'(lsu_busy_op), 32'h0);
            next_cycle();
            check_output({t, " misal end"}, 32'(misaligned_op), 32'h0);
            check_output({t, " req after"}, 32'(data_req_op), 32'h0);
            check_output({t, " load"}, load_mem_data_op, v.load);
        end else begin
            check_output({t, " req"}, 32'(data_req_op), 32'h1);
            check_output({t, " busy"}, 32'(lsu_busy_op), 32'h1);
            check_output({t, " addr"}, data_addr_op, {v.addr[31:2], 2'b00});
            check_output({t, " we"}, 32'(data_we_op), 32'(v.we));
            check_output({t, " be"}, 32'(data_be_op), 32'(v.be));
            if (v.we) begin
                check_output({t, " wdata"}, data_wdata_op, v.wdata);
            end
            data_gnt_i = 1'b1;
            next_cycle();
            data_gnt_i = 1'b0;
            check_output({t, " req dropped"}, 32'(data_req_op), 32'h0);
            check_output({t, " done early"}, 32'(lsu_done_op), 32'h0);
            data_rvalid_i = 1'b1;
            data_rdata_i  = v.rdata;
            next_cycle();
            data_rvalid_i = 1'b0;
            check_output({t, " done"}, 32'(lsu_done_op), 32'h1);
            check_output({t, " busy end"}, 32'(lsu_busy_op), 32'h0);
            check_output({t, " load"}, load_mem_data_op, v.load);
            next_cycle();
            check_output({t, " done pulse"}, 32'(lsu_done_op), 32'h0);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b0;
        lsu_en_ip       = 1'b0;
        alu_valid_ip    = 1'b0;
        lsu_operator_ip = 4'b0;
        mem_addr_ip     = 32'h0;
        store_data_ip   = 32'h0;
        data_gnt_i      = 1'b0;
        data_rvalid_i   = 1'b0;
        data_rdata_i    = 32'h0;

        //          op   addr          sdata         rdata         misal we    be       wdata         load
        vecs[0]  = '{SW,  32'h0000_1000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{LB,  32'h0000_1003, 32'h0,         32'h8011_2233, 1'b0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
        vecs[2]  = '{LBU, 32'h0000_1003, 32'h0,         32'h8011_2233, 1'b0, 1'b0, 4'b1000, 32'h0,         32'h0000_0080};
        vecs[3]  = '{LHU, 32'h0000_1002, 32'h0,         32'h8011_2233, 1'b0, 1'b0, 4'b1100, 32'h0,         32'h0000_8011};
        vecs[4]  = '{SH,  32'h0000_1002, 32'h0000_ABCD, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_8011};
        vecs[5]  = '{SB,  32'h0000_1001, 32'h0000_005A, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b0010, 32'h5A5A_5A5A, 32'h0000_8011};
        vecs[6]  = '{LW,  32'h0000_1002, 32'h0,         32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0000_8011};
        vecs[7]  = '{LH,  32'h0000_1001, 32'h0,         32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0000_8011};
        vecs[8]  = '{LH,  32'h0000_1002, 32'h0,         32'h8011_2233, 1'b0, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8011};
        vecs[9]  = '{LW,  32'h0000_2004, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 4'b1111, 32'h0,         32'h1234_5678};
        vecs[10] = '{LB,  32'h0000_1000, 32'h0,         32'h0000_00FF, 1'b0, 1'b0, 4'b0001, 32'h0,         32'hFFFF_FFFF};
        vecs[11] = '{SB,  32'h0000_1003, 32'h1122_3344, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b1000, 32'h4444_4444, 32'hFFFF_FFFF};
        vecs[12] = '{LBU, 32'h0000_1001, 32'h0,         32'hA1B2_C3D4, 1'b0, 1'b0, 4'b0010, 32'h0,         32'h0000_00C3};
        vecs[13] = '{LH,  32'h0000_1000, 32'h0,         32'h0000_7FFF, 1'b0, 1'b0, 4'b0011, 32'h0,         32'h0000_7FFF};

        #3;
        check_all_zero("reset");
        #14;
        reset = 1'b1;
        next_cycle();

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(i);
        end

        // Grant withheld for four request cycles: request and address must hold
        issue(LW, 32'h0000_3000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("stall req c%0d", k), 32'(data_req_op), 32'h1);
            check_output($sformatf("stall addr c%0d", k), data_addr_op, 32'h0000_3000);
            next_cycle();
        end
        data_gnt_i = 1'b1;
        next_cycle();
        data_gnt_i = 1'b0;
        check_output("stall req dropped", 32'(data_req_op), 32'h0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0BAD_CAFE;
        next_cycle();
        data_rvalid_i = 1'b0;
        check_output("stall done", 32'(lsu_done_op), 32'h1);
        check_output("stall load", load_mem_data_op, 32'h0BAD_CAFE);
        check_output("stall tmo", 32'(timeout_op), 32'h0);
        next_cycle();

        // No grant at all: eight busy cycles, then abort
        issue(SW, 32'h0000_4000, 32'h0000_0001);
        for (int k = 1; k <= 8; k++) begin
            check_output($sformatf("tmo busy c%0d", k), 32'(lsu_busy_op), 32'h1);
            check_output($sformatf("tmo early c%0d", k), 32'(timeout_op), 32'h0);
            next_cycle();
        end
        check_output("tmo pulse", 32'(timeout_op), 32'h1);
        check_output("tmo idle", 32'(lsu_busy_op), 32'h0);
        check_output("tmo req", 32'(data_req_op), 32'h0);
        check_output("tmo no done", 32'(lsu_done_op), 32'h0);
        check_output("tmo load kept", load_mem_data_op, 32'h0BAD_CAFE);
        next_cycle();
        check_output("tmo pulse end", 32'(timeout_op), 32'h0);

        // Response on the eighth busy cycle beats the timeout
        issue(LW, 32'h0000_5000, 32'h0);
        data_gnt_i = 1'b1;
        next_cycle();
        data_gnt_i = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            check_output($sformatf("race wait c%0d", k), 32'(lsu_busy_op), 32'h1);
            next_cycle();
        end
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1357_2468;
        next_cycle();
        data_rvalid_i = 1'b0;
        check_output("race done", 32'(lsu_done_op), 32'h1);
        check_output("race tmo", 32'(timeout_op), 32'h0);
        check_output("race load", load_mem_data_op, 32'h1357_2468);
        next_cycle();

        // Reset while waiting for the response, then a stray response afterwards
        issue(LW, 32'h0000_6000, 32'h0);
        data_gnt_i = 1'b1;
        next_cycle();
        data_gnt_i = 1'b0;
        check_output("rst wait busy", 32'(lsu_busy_op), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst async");
        next_cycle();
        reset         = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFF_FFFF;
        next_cycle();
        data_rvalid_i = 1'b0;
        check_output("rst stray done", 32'(lsu_done_op), 32'h0);
        check_output("rst stray busy", 32'(lsu_busy_op), 32'h0);
        check_output("rst stray load", load_mem_data_op, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
